// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle RV32M/RV64M multiply-divide unit:
// FSM encoding, M-extension opcode constants and operand signedness helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  localparam logic [2:0] MULFUNCT3    = 3'b000;
  localparam logic [2:0] MULHFUNCT3   = 3'b001;
  localparam logic [2:0] MULHSUFUNCT3 = 3'b010;
  localparam logic [2:0] MULHUFUNCT3  = 3'b011;
  localparam logic [2:0] DIVFUNCT3    = 3'b100;
  localparam logic [2:0] DIVUFUNCT3   = 3'b101;
  localparam logic [2:0] REMFUNCT3    = 3'b110;
  localparam logic [2:0] REMUFUNCT3   = 3'b111;

  function automatic logic is_signed_op1(input logic [2:0] f3);
    return (f3 == MULFUNCT3) || (f3 == MULHFUNCT3) || (f3 == MULHSUFUNCT3) ||
           (f3 == DIVFUNCT3) || (f3 == REMFUNCT3);
  endfunction

  function automatic logic is_signed_op2(input logic [2:0] f3);
    return (f3 == MULFUNCT3) || (f3 == MULHFUNCT3) ||
           (f3 == DIVFUNCT3) || (f3 == REMFUNCT3);
  endfunction

  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic is_rem_op(input logic [2:0] f3);
    return f3[2] && f3[1];
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and emit one quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  assign shifted  = {rem, quo[WIDTH-1]};
  assign diff     = shifted - {1'b0, divisor};
  assign borrow   = diff[WIDTH];
  // The remainder is always below the divisor, so it fits back into WIDTH bits.
  assign rem_next = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply-divide unit: shift-add multiply on operand
// magnitudes, restoring divide, sign fix-up and result select in DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH              = 32,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int MB = MUL_BITS_PER_CYCLE;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    MUL_ITERS = CW'(WIDTH / MB);
  localparam logic [CW-1:0]    DIV_ITERS = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               state;
  logic [2:0]           f3;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic                 neg_res;
  logic                 neg_rem;
  logic                 special;
  logic [WIDTH-1:0]     special_val;

  logic                 sign1;
  logic                 sign2;
  logic [WIDTH-1:0]     mag1;
  logic [WIDTH-1:0]     mag2;
  logic                 div_zero;
  logic                 div_ovf;
  logic [2*WIDTH-1:0]   mul_add;
  logic [WIDTH-1:0]     rem_next;
  logic [WIDTH-1:0]     quo_next;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     sel;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return -v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return -v;
  endfunction

  // Operand magnitudes; negating MIN_NEG wraps to itself, which is the
  // correct unsigned magnitude for the multiply paths.
  always_comb begin
    sign1    = is_signed_op1(f3) && a[WIDTH-1];
    sign2    = is_signed_op2(f3) && b[WIDTH-1];
    mag1     = sign1 ? neg_w(a) : a;
    mag2     = sign2 ? neg_w(b) : b;
    div_zero = (b == '0);
    div_ovf  = ((f3 == DIVFUNCT3) || (f3 == REMFUNCT3)) && (a == MIN_NEG) && (b == '1);
  end

  always_comb begin
    mul_add = '0;
    for (int i = 0; i < MB; i++) begin
      if (mplier[i]) mul_add = mul_add + (mcand << i);
    end
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc[2*WIDTH-1:WIDTH]),
    .quo      (acc[WIDTH-1:0]),
    .divisor  (mplier),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_comb begin
    prod = neg_res ? neg_2w(acc) : acc;
    unique case (f3)
      MULFUNCT3:                           sel = prod[WIDTH-1:0];
      MULHFUNCT3, MULHSUFUNCT3, MULHUFUNCT3: sel = prod[2*WIDTH-1:WIDTH];
      DIVFUNCT3, DIVUFUNCT3:
        sel = neg_res ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
      default:
        sel = neg_rem ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      busy        <= 1'b0;
      result      <= '0;
      f3          <= '0;
      a           <= '0;
      b           <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      special     <= 1'b0;
      special_val <= '0;
    end else begin
      unique case (state)
        // IDLE: latch the request; later input changes are ignored.
        IDLE: begin
          if (req_valid) begin
            f3        <= funct3;
            a         <= op1;
            b         <= op2;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= PREP;
          end
        end
        // PREP: magnitudes, result signs, iteration count, special cases.
        PREP: begin
          neg_res <= sign1 ^ sign2;
          neg_rem <= sign1;
          mcand   <= {{WIDTH{1'b0}}, mag1};
          mplier  <= mag2;
          acc     <= is_div_op(f3) ? {{WIDTH{1'b0}}, mag1} : '0;
          cnt     <= is_div_op(f3) ? DIV_ITERS : MUL_ITERS;
          if (is_div_op(f3) && (div_zero || div_ovf)) begin
            special <= 1'b1;
            if (div_zero) special_val <= is_rem_op(f3) ? a : '1;
            else          special_val <= is_rem_op(f3) ? '0 : a;
            state   <= DONE;
          end else begin
            special <= 1'b0;
            state   <= CALC;
          end
        end
        // CALC: one multiply digit or one quotient bit per cycle.
        CALC: begin
          if (is_div_op(f3)) begin
            acc <= {rem_next, quo_next};
          end else begin
            acc    <= acc + mul_add;
            mcand  <= mcand << MB;
            mplier <= mplier >> MB;
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        // DONE: register the corrected result, then hold until taken.
        DONE: begin
          if (!rsp_valid) begin
            result    <= special ? special_val : sel;
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, backpressure, reset
// during CALC and randomized operations against a plain-arithmetic model.
module tb_muldiv_unit;

  localparam int WIDTH = 32;
  localparam int MBPC  = 1;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(WIDTH), .MUL_BITS_PER_CYCLE(MBPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .funct3    (funct3),
    .op1       (op1),
    .op2       (op2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RISC-V M semantics expressed with 64-bit SystemVerilog arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                            input logic [31:0] y);
    longint     sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (f)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return '1;
        if (x == MIN_NEG && y == '1) return x;
        p = sx / sy; return p[31:0];
      end
      3'd5: begin
        if (y == 0) return '1;
        return x / y;
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == MIN_NEG && y == '1) return '0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] x,
                                     input logic [31:0] y);
    bit spec;
    spec = f[2] && ((y == 0) || (!f[0] && x == MIN_NEG && y == '1));
    if (spec) return 2;
    return (f[2] ? WIDTH : WIDTH / MBPC) + 2;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return '1;
      2:       return MIN_NEG;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_idle();
    int k = 0;
    while (!req_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!req_ready) chk("idle_timeout", 64'(req_ready), 64'(1));
  endtask

  // Returns just after the accept edge, with inputs scrambled to prove latching.
  task automatic start(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    wait_idle();
    funct3    = f;
    op1       = x;
    op2       = y;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    funct3    = 3'($urandom);
    op1       = $urandom;
    op2       = $urandom;
  endtask

  task automatic await_rsp(input string tag, input logic [31:0] exp, input int exp_lat);
    int lat = 0;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) begin
      chk({tag, "_timeout"}, 64'(rsp_valid), 64'(1));
    end else begin
      chk(tag, 64'(result), 64'(exp));
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                        input logic [31:0] y);
    logic [31:0] exp;
    exp = ref_model(f, x, y);
    start(f, x, y);
    await_rsp(tag, exp, ref_latency(f, x, y));
    if (!rsp_ready) begin
      repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
      chk({tag, "_hold"}, 64'(result), 64'(exp));
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, "_rsp_drop"}, 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_result",    64'(result),    64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("mul_8x2",  3'd0, 32'h0000_0008, 32'h0000_0002);
    run_op("mulh_m1",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu_m1",3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhu_m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op("divu_z",   3'd5, 32'h1234_5678, 32'h0000_0000);
    run_op("rem_z",    3'd6, 32'h1234_5678, 32'h0000_0000);
    run_op("div_ovf",  3'd4, MIN_NEG,       32'hFFFF_FFFF);
    run_op("rem_ovf",  3'd6, MIN_NEG,       32'hFFFF_FFFF);
    run_op("mul_min",  3'd1, MIN_NEG,       MIN_NEG);
    chk("ref_mulhu_m1", 64'(ref_model(3'd3, '1, '1)), 64'(32'hFFFF_FFFE));

    // Backpressure: response held, competing request must wait.
    rsp_ready = 1'b0;
    start(3'd0, 32'd7, 32'd6);
    await_rsp("bp_first", 32'd42, 34);
    funct3    = 3'd0;
    op1       = 32'd9;
    op2       = 32'd11;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_result", 64'(result), 64'(42));
      chk("bp_req_ready", 64'(req_ready), 64'(0));
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("bp_hs_req_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_accept_busy", 64'(busy), 64'(1));
    await_rsp("bp_next", 32'd99, 34);
    @(posedge clk); #1;

    // Reset during CALC discards the operation.
    start(3'd0, 32'd1234, 32'd5678);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy",      64'(busy),      64'(0));
    chk("mid_rst_req_ready", 64'(req_ready), 64'(1));
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) saw = 1'b1;
      @(posedge clk); #1;
    end
    chk("mid_rst_no_rsp", 64'(saw), 64'(0));
    run_op("post_rst_mul", 3'd0, 32'd3, 32'd5);
    chk("ref_3x5", 64'(ref_model(3'd0, 32'd3, 32'd5)), 64'(15));

    for (int n = 0; n < 300; n++) begin
      logic [2:0]  f;
      logic [31:0] x, y;
      f = 3'($urandom_range(0, 7));
      x = rand_operand();
      y = rand_operand();
      rsp_ready = ($urandom_range(0, 3) != 0);
      run_op($sformatf("rnd%0d_f%0d", n, f), f, x, y);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
